dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port, byte-addressed data memory.
- Shares the memory between port 0 (core load/store unit) and port 1 (debug/DMA master) using round-robin.
- Each granted request is sequenced through a fixed 3-state FSM.
- Misaligned and illegal accesses are rejected before they reach the memory.
- Memory-side signals are the memory's native controls: address, write data, is_load, is_store, funct3, and combinational read data; stores commit on the clock edge.

Parameters:
- ADDR_W, 32, address width for both requester and memory sides.
- ERR_RDATA, 32'h0000_0000, value returned on rdata for an errored access.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- p0_valid_i, p1_valid_i  in  1  request valid; held until the matching ack.
- p0_addr_i, p1_addr_i  in  ADDR_W  byte address.
- p0_wdata_i, p1_wdata_i  in  32  store data, LSB-aligned.
- p0_load_i, p1_load_i  in  1  load request.
- p0_store_i, p1_store_i  in  1  store request.
- p0_funct3_i, p1_funct3_i  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- p0_ack_o, p1_ack_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  load result; valid while an ack is high.
- err_o  out  1  error flag; valid while an ack is high.
- busy_o  out  1  high whenever the FSM is not IDLE.
- mem_address_o  out  ADDR_W  memory address.
- mem_write_data_o  out  32  memory write data.
- mem_is_load_o  out  1  memory load enable.
- mem_is_store_o  out  1  memory store enable.
- mem_funct3_o  out  3  memory size/sign code.
- mem_read_data_i  in  32  memory read data, combinational from mem_address_o.

Behaviour:
- Reset (asynchronous, active-high). State goes to IDLE. Every output is 0: acks, rdata_o, err_o, busy_o, and all mem_* outputs. The round-robin pointer last_grant is set to 1, so port 0 wins the first tie.
- IDLE:
  - If exactly one valid is high, grant that port.
  - If both are high, grant the port other than last_grant.
  - On grant, latch addr, wdata, load, store and funct3 into internal registers, set last_grant to the granted port, and go to ACCESS.
  - If neither is high, stay in IDLE.
- Error check, computed from the latched fields:
  - funct3 is not one of the five listed codes, or
  - load and store are both 1, or both 0, or
  - H/HU with addr[0] = 1, or
  - W with addr[1:0] != 00.
- ACCESS (exactly 1 cycle):
  - No error: drive mem_address_o, mem_write_data_o, mem_is_load_o, mem_is_store_o and mem_funct3_o from the latched fields. For a load, register mem_read_data_i into rdata_o at the end of the cycle. A store commits at the same edge.
  - Error: all mem_* outputs stay 0 (no memory side effect). Register err_o = 1 and rdata_o = ERR_RDATA.
  - Go to RESP.
- RESP (exactly 1 cycle):
  - Assert the granted port's ack_o.
  - rdata_o is 0 for a successful store.
  - Go to IDLE. Acks, err_o and rdata_o return to 0 on the next cycle.
- Outside ACCESS, every mem_* output is 0.
- Timing:
  - Latency: valid sampled in IDLE at edge N, ACCESS during cycle N+1, ack during cycle N+2.
  - Throughput: one transaction per 3 cycles.
  - A port still asserting valid in the cycle after its ack is treated as a new request.
- The requester must keep its request fields stable until ack. Dropping valid before ack is a protocol violation; the latched request still completes and still acks.
- A request arriving while busy_o is high waits. No request is lost.
- Fairness: with both ports continuously requesting, grants alternate strictly.
- rst_i asserted mid-transaction: the in-flight store is suppressed if rst_i rises before the ACCESS edge. No ack is issued, and the FSM returns to IDLE immediately.

Test Plan:
- Reset, then p0 SW addr 0x10 wdata 0xDEADBEEF; later p0 LW 0x10 -> ack in cycle N+2 each time, read rdata_o = 0xDEADBEEF, err_o = 0.
- p1 SB 0x13 wdata 0x80, then p1 LB 0x13 and LBU 0x13 -> rdata_o = 0xFFFFFF80 and 0x00000080.
- p0 and p1 both raise LW in the same cycle, held for 4 transactions -> grant order p0, p1, p0, p1; busy_o high continuously except one IDLE cycle between transactions.
- p0 SH addr 0x21; p1 LW addr 0x22; p0 funct3 011 -> each acks with err_o = 1 and rdata_o = 0; mem_is_store_o never asserts; memory is unchanged on readback.
- Start p0 SW 0x40 wdata 0x12345678 and assert rst_i during the ACCESS cycle -> no ack, all outputs 0, LW 0x40 afterwards returns 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and 3-state access sequencer for the data memory
module dmem_arbiter #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_valid_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [31:0]       p0_wdata_i,
    input  logic              p0_load_i,
    input  logic              p0_store_i,
    input  logic [2:0]        p0_funct3_i,
    input  logic              p1_valid_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_wdata_i,
    input  logic              p1_load_i,
    input  logic              p1_store_i,
    input  logic [2:0]        p1_funct3_i,
    output logic              p0_ack_o,
    output logic              p1_ack_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [31:0]       mem_write_data_o,
    output logic              mem_is_load_o,
    output logic              mem_is_store_o,
    output logic [2:0]        mem_funct3_o,
    input  logic [31:0]       mem_read_data_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state, state_next;
    logic                last_grant;
    logic                grant_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic                load_q;
    logic                store_q;
    logic [2:0]          funct3_q;

    logic                req_any;
    logic                req_port;
    logic                funct3_ok;
    logic                misaligned;
    logic                access_err;
    logic                mem_en;

    // Round-robin choice: a lone requester wins, a tie goes to the port not served last
    always_comb begin
        req_any  = p0_valid_i | p1_valid_i;
        req_port = 1'b0;
        if (p0_valid_i && p1_valid_i) begin
            req_port = ~last_grant;
        end else begin
            req_port = p1_valid_i;
        end
    end

    // Reject bad size codes, ambiguous load/store and misaligned halfword/word accesses
    always_comb begin
        funct3_ok  = (funct3_q == 3'b000) || (funct3_q == 3'b001) || (funct3_q == 3'b010) ||
                     (funct3_q == 3'b100) || (funct3_q == 3'b101);
        misaligned = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                     ((funct3_q == 3'b010) && (addr_q[1:0] != 2'b00));
        access_err = !funct3_ok || (load_q == store_q) || misaligned;
        mem_en     = (state == ACCESS) && !access_err;
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: IDLE waits for a request, ACCESS and RESP each last one cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_any) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture on grant, response capture in ACCESS, response clear after RESP
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            load_q     <= 1'b0;
            store_q    <= 1'b0;
            funct3_q   <= 3'b000;
            rdata_o    <= '0;
            err_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        last_grant <= req_port;
                        grant_q    <= req_port;
                        addr_q     <= req_port ? p1_addr_i   : p0_addr_i;
                        wdata_q    <= req_port ? p1_wdata_i  : p0_wdata_i;
                        load_q     <= req_port ? p1_load_i   : p0_load_i;
                        store_q    <= req_port ? p1_store_i  : p0_store_i;
                        funct3_q   <= req_port ? p1_funct3_i : p0_funct3_i;
                    end
                end
                ACCESS: begin
                    err_o <= access_err;
                    if (access_err) begin
                        rdata_o <= ERR_RDATA;
                    end else if (load_q) begin
                        rdata_o <= mem_read_data_i;
                    end else begin
                        rdata_o <= '0;
                    end
                end
                default: begin
                    err_o   <= 1'b0;
                    rdata_o <= '0;
                end
            endcase
        end
    end

    // Memory controls are live only during a clean ACCESS cycle; acks only during RESP
    always_comb begin
        mem_address_o    = mem_en ? addr_q   : '0;
        mem_write_data_o = mem_en ? wdata_q  : '0;
        mem_is_load_o    = mem_en & load_q;
        mem_is_store_o   = mem_en & store_q;
        mem_funct3_o     = mem_en ? funct3_q : 3'b000;
        p0_ack_o         = (state == RESP) && !grant_q;
        p1_ack_o         = (state == RESP) && grant_q;
        busy_o           = (state != IDLE);
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_valid, p1_valid;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic        p0_load, p1_load, p0_store, p1_store;
    logic [2:0]  p0_funct3, p1_funct3;
    logic        p0_ack, p1_ack, err, busy;
    logic [31:0] rdata;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_is_load, mem_is_store;
    logic [2:0]  mem_funct3;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          idle_cnt = 0;
    int          store_cnt = 0;
    logic        store_seen;
    logic [7:0]  mem [0:255];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .ERR_RDATA(32'h0000_0000)) dut (
        .clk_i(clk), .rst_i(rst),
        .p0_valid_i(p0_valid), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
        .p0_load_i(p0_load), .p0_store_i(p0_store), .p0_funct3_i(p0_funct3),
        .p1_valid_i(p1_valid), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
        .p1_load_i(p1_load), .p1_store_i(p1_store), .p1_funct3_i(p1_funct3),
        .p0_ack_o(p0_ack), .p1_ack_o(p1_ack), .rdata_o(rdata), .err_o(err), .busy_o(busy),
        .mem_address_o(mem_address), .mem_write_data_o(mem_write_data),
        .mem_is_load_o(mem_is_load), .mem_is_store_o(mem_is_store),
        .mem_funct3_o(mem_funct3), .mem_read_data_i(mem_read_data)
    );

    // Byte-addressed little-endian memory model, combinational sized/sign-extended read
    always_comb begin
        int unsigned b;
        logic [31:0] w;
        b = mem_address & 32'hFF;
        w = {mem[(b + 3) & 255], mem[(b + 2) & 255], mem[(b + 1) & 255], mem[b]};
        case (mem_funct3)
            3'b000:  mem_read_data = {{24{w[7]}}, w[7:0]};
            3'b001:  mem_read_data = {{16{w[15]}}, w[15:0]};
            3'b100:  mem_read_data = {24'h0, w[7:0]};
            3'b101:  mem_read_data = {16'h0, w[15:0]};
            default: mem_read_data = w;
        endcase
    end

    // Store commit on the clock edge, counting every store the memory sees
    always @(posedge clk) begin
        if (mem_is_store) begin
            int unsigned b;
            b = mem_address & 32'hFF;
            store_cnt <= store_cnt + 1;
            mem[b] <= mem_write_data[7:0];
            if (mem_funct3[1:0] != 2'b00) mem[(b + 1) & 255] <= mem_write_data[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                mem[(b + 2) & 255] <= mem_write_data[23:16];
                mem[(b + 3) & 255] <= mem_write_data[31:24];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed none expected event", tag);
    endtask

    task automatic push(input int port, input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        e.port  = port;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb.push_back(e);
    endtask

    task automatic drive(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic ld, input logic st, input logic [2:0] f3);
        if (port == 0) begin
            p0_addr = addr; p0_wdata = wdata; p0_load = ld; p0_store = st; p0_funct3 = f3;
            p0_valid = 1'b1;
        end else begin
            p1_addr = addr; p1_wdata = wdata; p1_load = ld; p1_store = st; p1_funct3 = f3;
            p1_valid = 1'b1;
        end
    endtask

    // Sample at falling edges until an ack, then pop the scoreboard and compare
    task automatic wait_ack(output int lat, output logic found);
        exp_t e;
        lat   = 0;
        found = 1'b0;
        store_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            lat++;
            if (!busy) idle_cnt++;
            if (mem_is_store) store_seen = 1'b1;
            if (p0_ack || p1_ack) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            fail_now("ack_timeout");
        end else if (sb.size() == 0) begin
            fail_now("scoreboard_underflow");
        end else begin
            e = sb.pop_front();
            chk("ack_pair", {30'h0, p1_ack, p0_ack}, (e.port == 0) ? 32'h1 : 32'h2);
            chk("rdata", rdata, e.rdata);
            chk("err", {31'h0, err}, {31'h0, e.err});
            chk("busy_at_ack", {31'h0, busy}, 32'h1);
        end
    endtask

    // One isolated transaction: valid driven before edge N, ack on the third falling edge (cycle N+2)
    task automatic txn(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] exp_rdata, input logic exp_err);
        int   lat;
        logic found;
        push(port, exp_rdata, exp_err);
        drive(port, addr, wdata, ld, st, f3);
        wait_ack(lat, found);
        chk("latency", lat, 32'd3);
        chk("store_issued", {31'h0, store_seen}, {31'h0, st && !exp_err});
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_ack_clear", {27'h0, p0_ack, p1_ack, err, busy}, 32'h0);
        chk("post_ack_rdata", rdata, 32'h0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {22'h0, p0_ack, p1_ack, err, busy, mem_is_load, mem_is_store, mem_funct3},
            32'h0);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_maddr"}, mem_address, 32'h0);
        chk({tag, "_mwdata"}, mem_write_data, 32'h0);
    endtask

    initial begin
        int   lat;
        int   stores_before;
        logic found;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst = 1'b1;
        p0_valid = 1'b0; p1_valid = 1'b0;
        p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
        p0_load = 1'b0; p1_load = 1'b0; p0_store = 1'b0; p1_store = 1'b0;
        p0_funct3 = 3'b000; p1_funct3 = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Word store then load on port 0
        txn(0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 3'b010, 32'h0, 1'b0);
        txn(0, 32'h10, 32'h0, 1'b1, 1'b0, 3'b010, 32'hDEADBEEF, 1'b0);

        // Byte store then signed and unsigned byte loads on port 1
        txn(1, 32'h13, 32'h80, 1'b0, 1'b1, 3'b000, 32'h0, 1'b0);
        txn(1, 32'h13, 32'h0, 1'b1, 1'b0, 3'b000, 32'hFFFFFF80, 1'b0);
        txn(1, 32'h13, 32'h0, 1'b1, 1'b0, 3'b100, 32'h00000080, 1'b0);

        // Both ports hold LW for four transactions: strict alternation starting at port 0
        push(0, 32'h80ADBEEF, 1'b0);
        push(1, 32'h00000000, 1'b0);
        push(0, 32'h80ADBEEF, 1'b0);
        push(1, 32'h00000000, 1'b0);
        idle_cnt = 0;
        drive(0, 32'h10, 32'h0, 1'b1, 1'b0, 3'b010);
        drive(1, 32'h14, 32'h0, 1'b1, 1'b0, 3'b010);
        for (int t = 0; t < 4; t++) begin
            wait_ack(lat, found);
            chk("rr_latency", lat, 32'd3);
        end
        chk("rr_idle_cycles", idle_cnt, 32'd4);
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        @(posedge clk);
        #1;

        // Rejected accesses: no store reaches memory, memory unchanged
        stores_before = store_cnt;
        txn(0, 32'h21, 32'hFFFF, 1'b0, 1'b1, 3'b001, 32'h0, 1'b1);
        txn(1, 32'h22, 32'h0, 1'b1, 1'b0, 3'b010, 32'h0, 1'b1);
        txn(0, 32'h10, 32'h0, 1'b1, 1'b0, 3'b011, 32'h0, 1'b1);
        chk("err_store_count", store_cnt, stores_before);
        txn(0, 32'h20, 32'h0, 1'b1, 1'b0, 3'b010, 32'h0, 1'b0);

        // Reset during ACCESS suppresses the store and the ack
        drive(0, 32'h40, 32'h12345678, 1'b0, 1'b1, 3'b010);
        @(posedge clk);
        #2;
        chk("pre_reset_store", {31'h0, mem_is_store}, 32'h1);
        rst = 1'b1;
        #1;
        p0_valid = 1'b0;
        chk_all_zero("midreset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_ack_in_reset", {30'h0, p1_ack, p0_ack}, 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        txn(0, 32'h40, 32'h0, 1'b1, 1'b0, 3'b010, 32'h0, 1'b0);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
